// File: rtl/hpdcache_params_pkg.sv
// HPDcache configuration defaults shared by cache sub-blocks.
// Only the write-buffer directory parameters are carried here.
package hpdcache_params_pkg;
    localparam int PARAM_WBUF_DIR_ENTRIES   = 16;
    localparam int PARAM_WBUF_TIMECNT_WIDTH = 4;
endpackage

// File: rtl/hpdcache_wbuf_flush_pkg.sv
// Shared types and helpers for the WBUF flush controller.
package hpdcache_wbuf_flush_pkg;
    typedef enum logic [1:0] {
        WBUF_FREE = 2'd0,
        WBUF_OPEN = 2'd1,
        WBUF_PEND = 2'd2,
        WBUF_SENT = 2'd3
    } wbuf_state_e;

    // Index width, never narrower than one bit even for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hpdcache_wbuf_flush_if.sv
// Memory write-request / acknowledge channel of the WBUF flush controller.
interface hpdcache_wbuf_flush_if #(
    parameter int IDX_W = 4
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [IDX_W-1:0] mem_req_idx;
    logic             mem_ack_valid;
    logic [IDX_W-1:0] mem_ack_idx;

    modport master (
        output mem_req_valid,
        output mem_req_idx,
        input  mem_req_ready,
        input  mem_ack_valid,
        input  mem_ack_idx
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_idx,
        output mem_req_ready,
        output mem_ack_valid,
        output mem_ack_idx
    );
endinterface

// File: rtl/hpdcache_wbuf_flush_arb.sv
// PEND-entry arbiter: fixed lowest-index priority, or round-robin when
// HPDCACHE_WBUF_FLUSH_RR_EN is defined. The selection is frozen while stalled.
module hpdcache_wbuf_flush_arb #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     pend_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    logic             hold_q;
    logic [IDX_W-1:0] hold_idx_q;
    logic [IDX_W-1:0] sel_idx;

    assign valid_o = |pend_i;

`ifdef HPDCACHE_WBUF_FLUSH_RR_EN
    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        logic found;
        int   j;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && pend_i[j]) begin
                sel_idx = IDX_W'(j);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (valid_o && ready_i) begin
            ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + IDX_W'(1);
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pend_i[k]) sel_idx = IDX_W'(k);
        end
    end
`endif

    // A stalled request keeps its index even if a better candidate appears.
    assign idx_o = hold_q ? hold_idx_q : sel_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hold_q <= 1'b0;
        else       hold_q <= valid_o & ~ready_i;
    end

    always_ff @(posedge clk_i) begin
        hold_idx_q <= idx_o;
    end
endmodule

// File: rtl/hpdcache_wbuf_flush_ctrl.sv
// WBUF directory flush controller: FREE -> OPEN -> PEND -> SENT -> FREE per entry.
// Define HPDCACHE_WBUF_FLUSH_RR_EN for round-robin flush arbitration.
module hpdcache_wbuf_flush_ctrl
    import hpdcache_wbuf_flush_pkg::*;
#(
    parameter int DIR_ENTRIES   = hpdcache_params_pkg::PARAM_WBUF_DIR_ENTRIES,
    parameter int TIMECNT_WIDTH = hpdcache_params_pkg::PARAM_WBUF_TIMECNT_WIDTH,
    localparam int IDX_W = idx_w(DIR_ENTRIES),
    localparam int TW    = (TIMECNT_WIDTH > 0) ? TIMECNT_WIDTH : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [IDX_W-1:0]     alloc_idx_o,
    input  logic                 wr_hit_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic                 flush_all_i,
    input  logic [TW-1:0]        cfg_threshold_i,
    hpdcache_wbuf_flush_if.master mem,
    output logic                 empty_o,
    output logic                 full_o
);
    wbuf_state_e            state_q [DIR_ENTRIES];
    wbuf_state_e            state_d [DIR_ENTRIES];
    logic [TW-1:0]          timer_q [DIR_ENTRIES];
    logic [TW-1:0]          timer_d [DIR_ENTRIES];
    logic [DIR_ENTRIES-1:0] free_vec;
    logic [DIR_ENTRIES-1:0] pend_vec;
    logic                   req_hs;

    always_comb begin
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            free_vec[i] = (state_q[i] == WBUF_FREE);
            pend_vec[i] = (state_q[i] == WBUF_PEND);
        end
    end

    always_comb begin
        alloc_idx_o = '0;
        for (int i = DIR_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx_o = IDX_W'(i);
        end
    end

    assign full_o      = ~|free_vec;
    assign empty_o     = &free_vec;
    assign alloc_gnt_o = alloc_req_i & ~full_o;
    assign req_hs      = mem.mem_req_valid & mem.mem_req_ready;

    hpdcache_wbuf_flush_arb #(
        .N     (DIR_ENTRIES),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pend_i  (pend_vec),
        .ready_i (mem.mem_req_ready),
        .valid_o (mem.mem_req_valid),
        .idx_o   (mem.mem_req_idx)
    );

    // Per-entry next state; each event class can only match one entry state.
    always_comb begin
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            unique case (state_q[i])
                WBUF_FREE: begin
                    if (alloc_gnt_o && alloc_idx_o == IDX_W'(i)) begin
                        state_d[i] = WBUF_OPEN;
                        timer_d[i] = '0;
                    end
                end
                WBUF_OPEN: begin
                    if (flush_all_i) begin
                        state_d[i] = WBUF_PEND;
                    end else if (wr_hit_i && wr_idx_i == IDX_W'(i)) begin
                        timer_d[i] = '0;
                    end else if ((TIMECNT_WIDTH == 0) || (timer_q[i] >= cfg_threshold_i)) begin
                        state_d[i] = WBUF_PEND;
                    end else if (timer_q[i] != '1) begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                WBUF_PEND: begin
                    if (req_hs && mem.mem_req_idx == IDX_W'(i)) state_d[i] = WBUF_SENT;
                end
                WBUF_SENT: begin
                    if (mem.mem_ack_valid && mem.mem_ack_idx == IDX_W'(i)) state_d[i] = WBUF_FREE;
                end
                default: state_d[i] = WBUF_FREE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i] <= WBUF_FREE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_hit_i && int'(wr_idx_i) < DIR_ENTRIES) begin
            assert (state_q[wr_idx_i] == WBUF_OPEN)
            else $warning("wbuf: write hit on non-OPEN entry %0d ignored", wr_idx_i);
        end
        if (!rst_i && mem.mem_ack_valid && int'(mem.mem_ack_idx) < DIR_ENTRIES) begin
            assert (state_q[mem.mem_ack_idx] == WBUF_SENT)
            else $warning("wbuf: ack to non-SENT entry %0d ignored", mem.mem_ack_idx);
        end
    end
`endif
endmodule
